// File: rtl/scan_mux.sv
// Registered N:1 word multiplexer with a built-in channel scanner.
// Manual mode presents sel_in; scan mode steps through channels, DWELL cycles each.
module scan_mux #(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 8,
  parameter  int DWELL    = 4,
  localparam int SEL_W    = ($clog2(CHANNELS) < 1) ? 1 : $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      hold,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          sel_out,
  output logic                      valid,
  output logic                      wrap
);

  localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [SEL_W-1:0]  LAST_CH = SEL_W'(CHANNELS - 1);
  localparam logic [DCNT_W-1:0] LAST_DW = DCNT_W'(DWELL - 1);

  logic [WIDTH-1:0]  r_out;
  logic [SEL_W-1:0]  r_sel_out;
  logic              r_valid;
  logic              r_wrap;
  logic [SEL_W-1:0]  r_ch;
  logic [DCNT_W-1:0] r_dcnt;

  logic [SEL_W-1:0]  w_idx;
  logic [WIDTH-1:0]  w_word;
  logic              w_hit;
  logic [SEL_W-1:0]  w_ch_nxt;
  logic [DCNT_W-1:0] w_dcnt_nxt;
  logic              w_wrap_nxt;

  assign w_idx = mode ? r_ch : sel_in;

  // Out-of-range selects match no channel, so the word falls back to zero
  // and w_hit doubles as the valid flag.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    w_word = '0;
    w_hit  = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_idx == SEL_W'(k)) begin
        w_word = data_in[k*WIDTH +: WIDTH];
        w_hit  = 1'b1;
      end
    end
  end

  // Scan sequencing: manual mode parks the counters at zero so the next
  // scan starts at channel 0 with a full dwell; mode=0 overrides hold.
  always_comb begin
    w_ch_nxt   = r_ch;
    w_dcnt_nxt = r_dcnt;
    w_wrap_nxt = 1'b0;
    if (!mode) begin
      w_ch_nxt   = '0;
      w_dcnt_nxt = '0;
    end else if (!hold) begin
      if (r_dcnt != LAST_DW) begin
        w_dcnt_nxt = r_dcnt + 1'b1;
      end else begin
        w_dcnt_nxt = '0;
        if (r_ch == LAST_CH) begin
          w_ch_nxt   = '0;
          w_wrap_nxt = 1'b1;
        end else begin
          w_ch_nxt = r_ch + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out     <= '0;
      r_sel_out <= '0;
      r_valid   <= 1'b0;
      r_wrap    <= 1'b0;
      r_ch      <= '0;
      r_dcnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_out     <= w_word;
      r_sel_out <= w_idx;
      r_valid   <= w_hit;
      r_wrap    <= w_wrap_nxt;
      r_ch      <= w_ch_nxt;
      r_dcnt    <= w_dcnt_nxt;
    end
  end

  assign out     = r_out;
  assign sel_out = r_sel_out;
  assign valid   = r_valid;
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: 8 channels/DWELL=2, 6 channels, and 8 channels/DWELL=1.
module tb_scan_mux;

  logic         clk = 1'b0;
  logic         reset;
  logic         mode;
  logic         hold;
  logic [2:0]   sel_in;
  logic [127:0] data8;
  logic [95:0]  data6;

  logic [15:0] out_a, out_b, out_c;
  logic [2:0]  sel_a, sel_b, sel_c;
  logic        valid_a, valid_b, valid_c;
  logic        wrap_a, wrap_b, wrap_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  scan_mux #(.WIDTH(16), .CHANNELS(8), .DWELL(2)) dut_a (
    .clk(clk), .reset(reset), .data_in(data8), .mode(mode), .sel_in(sel_in),
    .hold(hold), .out(out_a), .sel_out(sel_a), .valid(valid_a), .wrap(wrap_a));

  scan_mux #(.WIDTH(16), .CHANNELS(6), .DWELL(2)) dut_b (
    .clk(clk), .reset(reset), .data_in(data6), .mode(mode), .sel_in(sel_in),
    .hold(hold), .out(out_b), .sel_out(sel_b), .valid(valid_b), .wrap(wrap_b));

  scan_mux #(.WIDTH(16), .CHANNELS(8), .DWELL(1)) dut_c (
    .clk(clk), .reset(reset), .data_in(data8), .mode(mode), .sel_in(sel_in),
    .hold(hold), .out(out_c), .sel_out(sel_c), .valid(valid_c), .wrap(wrap_c));

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart_scan();
    reset = 1'b1;
    mode  = 1'b1;
    hold  = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    n_tests++;
    if (out_a !== 16'h0) begin n_fail++; $display("FAIL reset_out got %h exp 0000", out_a); end
    n_tests++;
    if (sel_a !== 3'd0) begin n_fail++; $display("FAIL reset_sel got %0d exp 0", sel_a); end
    n_tests++;
    if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid_a); end
    n_tests++;
    if (wrap_a !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got %b exp 0", wrap_a); end
  endtask

  task automatic test_scan_pass();
    restart_scan();
    for (int e = 1; e <= 17; e++) begin
      logic [2:0]  es;
      logic [15:0] eo;
      logic        ew;
      step();
      es = 3'((e - 1) / 2);
      eo = 16'hA000 + 16'(es);
      ew = (e == 16);
      n_tests++;
      if (out_a !== eo || sel_a !== es || valid_a !== 1'b1 || wrap_a !== ew) begin
        n_fail++;
        $display("FAIL scan_pass edge %0d got out=%h sel=%0d valid=%b wrap=%b exp out=%h sel=%0d valid=1 wrap=%b",
                 e, out_a, sel_a, valid_a, wrap_a, eo, es, ew);
      end
    end
  endtask

  task automatic test_manual();
    mode   = 1'b0;
    sel_in = 3'd3;
    step();
    n_tests++;
    if (out_a !== 16'hA003 || sel_a !== 3'd3 || valid_a !== 1'b1 || wrap_a !== 1'b0) begin
      n_fail++;
      $display("FAIL manual_sel3 got out=%h sel=%0d valid=%b wrap=%b exp out=a003 sel=3 valid=1 wrap=0",
               out_a, sel_a, valid_a, wrap_a);
    end
    sel_in = 3'd5;
    #1;
    n_tests++;
    if (out_a !== 16'hA003) begin n_fail++; $display("FAIL manual_latency got %h exp a003", out_a); end
    step();
    n_tests++;
    if (out_a !== 16'hA005 || sel_a !== 3'd5 || valid_a !== 1'b1 || wrap_a !== 1'b0) begin
      n_fail++;
      $display("FAIL manual_sel5 got out=%h sel=%0d valid=%b wrap=%b exp out=a005 sel=5 valid=1 wrap=0",
               out_a, sel_a, valid_a, wrap_a);
    end
  endtask

  task automatic test_hold();
    restart_scan();
    for (int e = 1; e <= 10; e++) begin
      logic [2:0]  es;
      logic [15:0] eo;
      step();
      if (e <= 4)      es = 3'((e - 1) / 2);
      else if (e <= 9) es = 3'd2;
      else             es = 3'd3;
      eo = (e == 7 || e == 8) ? 16'h5522 : 16'hA000 + 16'(es);
      n_tests++;
      if (out_a !== eo || sel_a !== es || wrap_a !== 1'b0) begin
        n_fail++;
        $display("FAIL hold edge %0d got out=%h sel=%0d wrap=%b exp out=%h sel=%0d wrap=0",
                 e, out_a, sel_a, wrap_a, eo, es);
      end
      hold = (e + 1 >= 6) && (e + 1 <= 8);
      if (e == 6) data8[2*16 +: 16] = 16'h5522;
      if (e == 8) data8[2*16 +: 16] = 16'hA002;
    end
    hold = 1'b0;
  endtask

  task automatic test_range();
    mode   = 1'b0;
    sel_in = 3'd7;
    step();
    n_tests++;
    if (out_b !== 16'h0 || valid_b !== 1'b0 || sel_b !== 3'd7) begin
      n_fail++;
      $display("FAIL range_sel7 got out=%h valid=%b sel=%0d exp out=0000 valid=0 sel=7", out_b, valid_b, sel_b);
    end
    sel_in = 3'd6;
    step();
    n_tests++;
    if (out_b !== 16'h0 || valid_b !== 1'b0 || sel_b !== 3'd6) begin
      n_fail++;
      $display("FAIL range_sel6 got out=%h valid=%b sel=%0d exp out=0000 valid=0 sel=6", out_b, valid_b, sel_b);
    end
    sel_in = 3'd5;
    step();
    n_tests++;
    if (out_b !== 16'hB005 || valid_b !== 1'b1 || sel_b !== 3'd5) begin
      n_fail++;
      $display("FAIL range_sel5 got out=%h valid=%b sel=%0d exp out=b005 valid=1 sel=5", out_b, valid_b, sel_b);
    end
  endtask

  task automatic test_async_reset();
    restart_scan();
    for (int e = 1; e <= 11; e++) step();
    n_tests++;
    if (sel_a !== 3'd5) begin n_fail++; $display("FAIL pre_reset_sel got %0d exp 5", sel_a); end
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (out_a !== 16'h0 || sel_a !== 3'd0 || valid_a !== 1'b0 || wrap_a !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got out=%h sel=%0d valid=%b wrap=%b exp all zero", out_a, sel_a, valid_a, wrap_a);
    end
    step();
    reset = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      logic [2:0] es;
      step();
      es = 3'((e - 1) / 2);
      n_tests++;
      if (out_a !== 16'hA000 + 16'(es) || sel_a !== es) begin
        n_fail++;
        $display("FAIL post_reset edge %0d got out=%h sel=%0d exp sel=%0d", e, out_a, sel_a, es);
      end
    end
  endtask

  task automatic test_mode_switch();
    mode   = 1'b0;
    sel_in = 3'd4;
    step();
    n_tests++;
    if (sel_a !== 3'd4 || out_a !== 16'hA004) begin
      n_fail++;
      $display("FAIL switch_manual got out=%h sel=%0d exp out=a004 sel=4", out_a, sel_a);
    end
    mode = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      logic [2:0] es_a;
      logic [2:0] es_c;
      logic       ew_c;
      step();
      es_a = 3'((e - 1) / 2);
      es_c = 3'((e - 1) % 8);
      ew_c = (e % 8 == 0);
      n_tests++;
      if (sel_a !== es_a || out_a !== 16'hA000 + 16'(es_a)) begin
        n_fail++;
        $display("FAIL switch_scan edge %0d got out=%h sel=%0d exp sel=%0d", e, out_a, sel_a, es_a);
      end
      n_tests++;
      if (sel_c !== es_c || out_c !== 16'hA000 + 16'(es_c) || wrap_c !== ew_c) begin
        n_fail++;
        $display("FAIL dwell1 edge %0d got out=%h sel=%0d wrap=%b exp sel=%0d wrap=%b",
                 e, out_c, sel_c, wrap_c, es_c, ew_c);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    mode   = 1'b0;
    hold   = 1'b0;
    sel_in = 3'd0;
    for (int k = 0; k < 8; k++) data8[k*16 +: 16] = 16'hA000 + 16'(k);
    for (int k = 0; k < 6; k++) data6[k*16 +: 16] = 16'hB000 + 16'(k);
    test_reset();
    test_scan_pass();
    test_manual();
    test_hold();
    test_range();
    test_async_reset();
    test_mode_switch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
